cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_pkg.sv | 31 +++
 rtl/mem_1w1r_async.sv | 31 +++
 rtl/cpu_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: FSM state encoding,
// default bus widths and the host-load target select values.
package cpu_mem_pkg;

    // Default widths. depth = 2**DEF_ADDR_W
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    // Loader FSM states. The encoding is visible on the debug 'state' port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // ld_sel values: which memory a host word is written into
    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

    // States in which the host stream is open
    function automatic logic state_accepts_host(input state_t s);
        return (s == ST_IDLE) || (s == ST_LOAD);
    endfunction

    // States in which the CPU is enabled
    function automatic logic state_cpu_enabled(input state_t s);
        return (s == ST_START) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/mem_1w1r_async.sv
// Word-addressed memory with one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
module mem_1w1r_async
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: one word per rising edge when we is high
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: zero-latency combinational lookup
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side partner of the CPU: instruction and data memories plus a
// host loader FSM that fills both memories and then starts the CPU.
//
// Host stream handshake: a word transfers on a rising clock edge where
// ld_valid and ld_ready are both 1. ld_ready is a registered output that is
// 1 only in IDLE and LOAD (and 0 during and the cycle after reset); the host
// holds ld_valid/ld_sel/ld_data/ld_last stable until the transfer happens.
// ld_valid while ld_ready is 0 has no effect.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    // CPU instruction port
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    // CPU data port
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_datain,
    // Host load stream
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    // Run control
    input  logic              run_stop,
    output logic              enable,
    output logic              start,
    // Debug / status
    output logic [1:0]        state,
    output logic              ld_overflow
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic              ld_ready_q;
    logic              enable_q;
    logic              start_q;
    logic              ovf_q;
    logic [ADDR_W-1:0] ia_q;
    logic [ADDR_W-1:0] da_q;

    logic              accept;
    logic              host_imem_we;
    logic              host_dmem_we;
    logic              stop_run;

    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0] dmem_wdata;

    // A host word transfers only when the registered ready is high
    assign accept       = ld_valid && ld_ready_q;
    assign host_imem_we = accept && (ld_sel == SEL_IMEM);
    assign host_dmem_we = accept && (ld_sel == SEL_DMEM);
    assign stop_run     = (state_q == ST_RUN) && run_stop;

    // Next-state logic of the loader FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ld_last ? ST_START : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && ld_last) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (run_stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; ready/enable/start are decoded from the next state so
    // they come straight out of flops with no input-to-output path
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ld_ready_q <= 1'b0;
            enable_q   <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_ready_q <= state_accepts_host(state_d);
            enable_q   <= state_cpu_enabled(state_d);
            start_q    <= (state_d == ST_START);
        end
    end

    // Load address counters and sticky wrap flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            ia_q  <= '0;
            da_q  <= '0;
            ovf_q <= 1'b0;
        end else if (stop_run) begin
            // Returning to IDLE starts a fresh image at address 0
            ia_q <= '0;
            da_q <= '0;
        end else begin
            if (host_imem_we) begin
                ia_q <= ia_q + ADDR_ONE;
                if (ia_q == ADDR_MAX) begin
                    ovf_q <= 1'b1;
                end
            end
            if (host_dmem_we) begin
                da_q <= da_q + ADDR_ONE;
                if (da_q == ADDR_MAX) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // dmem write port: CPU owns it in RUN, the host loader otherwise
    always_comb begin
        dmem_we    = 1'b0;
        dmem_waddr = da_q;
        dmem_wdata = ld_data;
        if (state_q == ST_RUN) begin
            dmem_we    = d_we;
            dmem_waddr = d_addr;
            dmem_wdata = d_dataout;
        end else begin
            dmem_we    = host_dmem_we;
        end
    end

    mem_1w1r_async #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk     (clock),
        .we      (host_imem_we),
        .wr_addr (ia_q),
        .wr_data (ld_data),
        .rd_addr (i_addr),
        .rd_data (i_datain)
    );

    mem_1w1r_async #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clock),
        .we      (dmem_we),
        .wr_addr (dmem_waddr),
        .wr_data (dmem_wdata),
        .rd_addr (d_addr),
        .rd_data (d_datain)
    );

    assign state       = state_q;
    assign ld_ready    = ld_ready_q;
    assign enable      = enable_q;
    assign start       = start_q;
    assign ld_overflow = ovf_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed tables, hand-written
// multi-cycle sequences and randomized load/run sessions checked against a
// simple memory-image model.
module tb_cpu_mem_responder;

    logic        clock;
    logic        reset;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_sel;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        run_stop;
    logic        enable;
    logic        start;
    logic [1:0]  state;
    logic        ld_overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected memory images, which words are defined,
    // words written so far in the current load session, sticky wrap flag
    logic [15:0] imem_m [256];
    logic [15:0] dmem_m [256];
    bit          known_i [256];
    bit          known_d [256];
    int          n_i;
    int          n_d;
    bit          ovf_m;

    cpu_mem_responder dut (
        .clock       (clock),
        .reset       (reset),
        .i_addr      (i_addr),
        .i_datain    (i_datain),
        .d_addr      (d_addr),
        .d_dataout   (d_dataout),
        .d_we        (d_we),
        .d_datain    (d_datain),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_sel      (ld_sel),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .run_stop    (run_stop),
        .enable      (enable),
        .start       (start),
        .state       (state),
        .ld_overflow (ld_overflow)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic new_session();
        n_i = 0;
        n_d = 0;
    endtask

    // Offer one host word, wait (bounded) for ready, transfer it on the next edge
    task automatic send(input logic sel, input logic [15:0] data, input logic last);
        int wait_n;
        int a;
        wait_n   = 0;
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_data  = data;
        ld_last  = last;
        while (ld_ready !== 1'b1 && wait_n < 20) begin
            tick();
            wait_n++;
        end
        if (wait_n >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_ready_timeout actual=%0b required=1", ld_ready);
        end
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (sel == 1'b0) begin
            a = n_i % 256;
            imem_m[a]  = data;
            known_i[a] = 1'b1;
            n_i++;
            if (n_i >= 256) ovf_m = 1'b1;
        end else begin
            a = n_d % 256;
            dmem_m[a]  = data;
            known_d[a] = 1'b1;
            n_d++;
            if (n_d >= 256) ovf_m = 1'b1;
        end
    endtask

    task automatic check_imem(input logic [7:0] a, input string name);
        i_addr = a;
        #1;
        if (known_i[a]) check(name, i_datain, imem_m[a]);
    endtask

    task automatic check_dmem(input logic [7:0] a, input string name);
        d_addr = a;
        #1;
        if (known_d[a]) check(name, d_datain, dmem_m[a]);
    endtask

    // One CPU cycle in RUN: optional store, model updated on the edge
    task automatic cpu_cycle(input logic we, input logic [7:0] a, input logic [15:0] v);
        d_we      = we;
        d_addr    = a;
        d_dataout = v;
        tick();
        d_we = 1'b0;
        if (we) begin
            dmem_m[a]  = v;
            known_d[a] = 1'b1;
        end
    endtask

    // RUN -> IDLE via run_stop
    task automatic stop_cpu(input string name);
        run_stop = 1'b1;
        tick();
        run_stop = 1'b0;
        check({name, "_state"}, state, 2'd0);
        check({name, "_enable"}, enable, 1'b0);
        check({name, "_ready"}, ld_ready, 1'b1);
        new_session();
    endtask

    // After the last word: start pulse, then RUN
    task automatic check_start_run(input string name);
        check({name, "_start_state"}, state, 2'd2);
        check({name, "_start_pulse"}, start, 1'b1);
        check({name, "_start_enable"}, enable, 1'b1);
        check({name, "_start_ready"}, ld_ready, 1'b0);
        tick();
        check({name, "_run_state"}, state, 2'd3);
        check({name, "_run_start"}, start, 1'b0);
        check({name, "_run_enable"}, enable, 1'b1);
    endtask

    typedef struct {
        logic        sel;
        logic [15:0] data;
        logic        last;
        logic [1:0]  exp_state;
    } ld_vec_t;

    typedef struct {
        logic        sel;
        logic [7:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    ld_vec_t ld_tab [3];
    rd_vec_t rd_tab [6];

    initial begin
        logic [15:0] w;
        logic [15:0] w256;
        logic [15:0] w257;
        int          n;

        ld_tab[0] = '{1'b0, 16'h1111, 1'b0, 2'd1};
        ld_tab[1] = '{1'b0, 16'h2222, 1'b0, 2'd1};
        ld_tab[2] = '{1'b0, 16'h3333, 1'b1, 2'd2};

        rd_tab[0] = '{1'b0, 8'h00, 16'h1111};
        rd_tab[1] = '{1'b0, 8'h01, 16'h2222};
        rd_tab[2] = '{1'b0, 8'h02, 16'h3333};
        rd_tab[3] = '{1'b1, 8'h00, 16'hff00};
        rd_tab[4] = '{1'b1, 8'h05, 16'hff80};
        rd_tab[5] = '{1'b1, 8'h10, 16'h0bad};

        for (int i = 0; i < 256; i++) begin
            known_i[i] = 1'b0;
            known_d[i] = 1'b0;
            imem_m[i]  = '0;
            dmem_m[i]  = '0;
        end
        ovf_m = 1'b0;
        new_session();

        reset     = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_dataout = '0;
        d_we      = 1'b0;
        ld_valid  = 1'b1;
        ld_sel    = 1'b0;
        ld_data   = 16'h7777;
        ld_last   = 1'b0;
        run_stop  = 1'b0;

        // Reset held with ld_valid asserted
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_state", state, 2'd0);
            check("rst_enable", enable, 1'b0);
            check("rst_start", start, 1'b0);
            check("rst_ready", ld_ready, 1'b0);
            check("rst_ovf", ld_overflow, 1'b0);
        end
        ld_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("rel_ready", ld_ready, 1'b1);
        check("rel_state", state, 2'd0);

        // imem load from the table, state checked after each word
        for (int k = 0; k < 3; k++) begin
            send(ld_tab[k].sel, ld_tab[k].data, ld_tab[k].last);
            check($sformatf("tab_state_%0d", k), state, ld_tab[k].exp_state);
        end
        check_start_run("img1");

        // dmem single-word image, then CPU stores
        stop_cpu("stop1");
        send(1'b1, 16'hff00, 1'b1);
        check_start_run("img2");
        cpu_cycle(1'b1, 8'h05, 16'hff80);
        check("store_rd", d_datain, 16'hff80);
        cpu_cycle(1'b1, 8'h10, 16'h0bad);
        check_dmem(8'h00, "dmem0_rd");

        // Fixed read-back table
        for (int k = 0; k < 6; k++) begin
            if (rd_tab[k].sel == 1'b0) begin
                i_addr = rd_tab[k].addr;
                #1;
                check($sformatf("rdtab_i_%0d", k), i_datain, rd_tab[k].exp);
            end else begin
                d_addr = rd_tab[k].addr;
                #1;
                check($sformatf("rdtab_d_%0d", k), d_datain, rd_tab[k].exp);
            end
        end

        // CPU store attempt during LOAD must be ignored
        stop_cpu("stop2");
        send(1'b0, 16'h4444, 1'b0);
        check("load_state", state, 2'd1);
        cpu_cycle(1'b1, 8'h10, 16'hdead);
        known_d[8'h10] = 1'b1;
        dmem_m[8'h10]  = 16'h0bad;
        check("load_dwe_ignored", d_datain, 16'h0bad);
        check("load_state_hold", state, 2'd1);
        send(1'b1, 16'h5555, 1'b1);
        check_start_run("img3");
        check_imem(8'h00, "img3_i0");
        check_dmem(8'h00, "img3_d0");

        // run_stop ignored outside RUN is exercised in LOAD below; 257-word wrap
        stop_cpu("stop3");
        check("pre_wrap_ovf", ld_overflow, 1'b0);
        w256 = '0;
        w257 = '0;
        for (int k = 1; k <= 257; k++) begin
            w = 16'($urandom);
            if (k == 256) w256 = w;
            if (k == 257) w257 = w;
            run_stop = (k == 100);
            send(1'b0, w, k == 257);
            run_stop = 1'b0;
            if (k == 100) check("load_runstop_ignored", state, 2'd1);
            if (k == 255) check("ovf_before_wrap", ld_overflow, 1'b0);
            if (k == 256) check("ovf_after_wrap", ld_overflow, 1'b1);
        end
        i_addr = 8'h00;
        #1;
        check("wrap_i0", i_datain, w257);
        i_addr = 8'hff;
        #1;
        check("wrap_i255", i_datain, w256);
        check_start_run("img4");
        check("ovf_in_run", ld_overflow, ovf_m);

        // Randomized load/run sessions against the image model
        for (int s = 0; s < 6; s++) begin
            stop_cpu($sformatf("rstop%0d", s));
            check($sformatf("r%0d_ovf_kept", s), ld_overflow, ovf_m);
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                send(1'($urandom), 16'($urandom), k == n - 1);
            end
            check_start_run($sformatf("r%0d", s));
            for (int c = 0; c < 25; c++) begin
                // Host words offered while running must be dropped
                ld_valid = 1'($urandom);
                ld_sel   = 1'($urandom);
                ld_data  = 16'($urandom);
                ld_last  = 1'($urandom);
                cpu_cycle(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
                check_dmem(8'($urandom_range(0, 15)), $sformatf("r%0d_dmem", s));
                check_imem(8'($urandom_range(0, 15)), $sformatf("r%0d_imem", s));
            end
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            check($sformatf("r%0d_still_run", s), state, 2'd3);
        end

        // Reset in the middle of a load keeps memory, clears control state
        stop_cpu("stop4");
        send(1'b0, 16'habcd, 1'b0);
        send(1'b0, 16'h1357, 1'b0);
        check("mid_load_state", state, 2'd1);
        reset = 1'b0;
        tick();
        check("midrst_state", state, 2'd0);
        check("midrst_enable", enable, 1'b0);
        check("midrst_start", start, 1'b0);
        check("midrst_ready", ld_ready, 1'b0);
        check("midrst_ovf", ld_overflow, 1'b0);
        ovf_m = 1'b0;
        reset = 1'b1;
        new_session();
        tick();
        check("postrst_ready", ld_ready, 1'b1);
        i_addr = 8'h00;
        #1;
        check("postrst_i0", i_datain, 16'habcd);
        send(1'b0, 16'h2468, 1'b1);
        check_imem(8'h00, "reload_i0");
        i_addr = 8'h01;
        #1;
        check("reload_i1_kept", i_datain, 16'h1357);
        check_start_run("img5");
        check("final_ovf", ld_overflow, ovf_m);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
